// File: rtl/datapath_seq.sv
// Sequenced datapath: a register file, A/B/C pipeline registers, shifter, operand muxes, ALU and flags.
// A command starts one complete multi-cycle operation, and its result is handed off on a valid/ready channel.
module datapath_seq #(
    parameter  int WIDTH = 16,
    parameter  int NREGS = 8,
    parameter  int IMM_W = 5,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [RW-1:0]    cmd_rd,
    input  logic [RW-1:0]    cmd_rn,
    input  logic [RW-1:0]    cmd_rm,
    input  logic [1:0]       cmd_shift,
    input  logic [1:0]       cmd_aluop,
    input  logic             cmd_asel,
    input  logic             cmd_bsel,
    input  logic [IMM_W-1:0] cmd_imm,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v
);

    typedef enum logic [2:0] {IDLE, RDA, RDB, EXEC, DONE} state_e;
    typedef enum logic [1:0] {OP_WRI, OP_ALU, OP_CMP, OP_RSV} op_e;
    typedef enum logic [1:0] {SH_NONE, SH_LSL1, SH_LSR1, SH_ASR1} shift_e;
    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_MVN} aluop_e;

    state_e state_q, state_d;

    op_e              op_q;
    logic [RW-1:0]    rd_q, rn_q, rm_q;
    shift_e           shift_q;
    aluop_e           aluop_q;
    logic             asel_q, bsel_q;
    logic [IMM_W-1:0] imm_q;
    logic [WIDTH-1:0] data_q;

    logic [WIDTH-1:0] regFile_q [NREGS];
    logic [WIDTH-1:0] regA_q, regB_q, regC_q;
    logic             flagZ_q, flagN_q, flagV_q;

    logic             accept, loadA, loadB, execEn;
    logic [WIDTH-1:0] shifted, aIn, bIn, aluRes;
    logic             aluV;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Commands are accepted only in IDLE, and never while reset is asserted.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        accept    = 1'b0;
        loadA     = 1'b0;
        loadB     = 1'b0;
        execEn    = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = !reset;
                accept    = cmd_valid && !reset;
                if (accept) state_d = (op_e'(cmd_op) == OP_WRI) ? EXEC : RDA;
            end
            RDA: begin
                loadA   = 1'b1;
                state_d = RDB;
            end
            RDB: begin
                loadB   = 1'b1;
                state_d = EXEC;
            end
            EXEC: begin
                execEn  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                res_valid = !reset;
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shifted = regB_q;
        case (shift_q)
            SH_NONE: shifted = regB_q;
            SH_LSL1: shifted = {regB_q[WIDTH-2:0], 1'b0};
            SH_LSR1: shifted = {1'b0, regB_q[WIDTH-1:1]};
            SH_ASR1: shifted = {regB_q[WIDTH-1], regB_q[WIDTH-1:1]};
            default: shifted = regB_q;
        endcase
        aIn = asel_q ? '0 : regA_q;
        bIn = bsel_q ? WIDTH'(imm_q) : shifted;
    end

    // Overflow only makes sense for the arithmetic ops; the logical ops report V=0.
    always_comb begin
        aluRes = '0;
        aluV   = 1'b0;
        case (aluop_q)
            ALU_ADD: begin
                aluRes = aIn + bIn;
                aluV   = (aIn[WIDTH-1] == bIn[WIDTH-1]) && (aluRes[WIDTH-1] != aIn[WIDTH-1]);
            end
            ALU_SUB: begin
                aluRes = aIn - bIn;
                aluV   = (aIn[WIDTH-1] != bIn[WIDTH-1]) && (aluRes[WIDTH-1] != aIn[WIDTH-1]);
            end
            ALU_AND: aluRes = aIn & bIn;
            ALU_MVN: aluRes = ~bIn;
            default: aluRes = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q    <= OP_WRI;
            rd_q    <= '0;
            rn_q    <= '0;
            rm_q    <= '0;
            shift_q <= SH_NONE;
            aluop_q <= ALU_ADD;
            asel_q  <= 1'b0;
            bsel_q  <= 1'b0;
            imm_q   <= '0;
            data_q  <= '0;
            regA_q  <= '0;
            regB_q  <= '0;
            regC_q  <= '0;
            flagZ_q <= 1'b0;
            flagN_q <= 1'b0;
            flagV_q <= 1'b0;
            for (int i = 0; i < NREGS; i++) regFile_q[i] <= '0;
        end else begin
            if (accept) begin
                op_q    <= op_e'(cmd_op);
                rd_q    <= cmd_rd;
                rn_q    <= cmd_rn;
                rm_q    <= cmd_rm;
                shift_q <= shift_e'(cmd_shift);
                aluop_q <= aluop_e'(cmd_aluop);
                asel_q  <= cmd_asel;
                bsel_q  <= cmd_bsel;
                imm_q   <= cmd_imm;
                data_q  <= cmd_data;
            end
            if (loadA) regA_q <= regFile_q[rn_q];
            if (loadB) regB_q <= regFile_q[rm_q];
            // The single register-file write port is used only here, in EXEC.
            if (execEn) begin
                if (op_q == OP_WRI) begin
                    regC_q          <= data_q;
                    regFile_q[rd_q] <= data_q;
                end else begin
                    regC_q  <= aluRes;
                    flagZ_q <= (aluRes == '0);
                    flagN_q <= aluRes[WIDTH-1];
                    flagV_q <= aluV;
                    if (op_q == OP_ALU) regFile_q[rd_q] <= aluRes;
                end
            end
        end
    end

    assign res_data = regC_q;
    assign flag_z   = flagZ_q;
    assign flag_n   = flagN_q;
    assign flag_v   = flagV_q;

endmodule

// File: tb/tb_datapath_seq.sv
// Bench for datapath_seq: vector table plus scoreboard on the 16-bit build, and hand sequences
// for stalls, mid-operation reset and a small 8-bit/4-register build.
module tb_datapath_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op, cmd_shift, cmd_aluop;
    logic [2:0]  cmd_rd, cmd_rn, cmd_rm;
    logic        cmd_asel, cmd_bsel;
    logic [4:0]  cmd_imm;
    logic [15:0] cmd_data;
    logic        res_valid, res_ready;
    logic [15:0] res_data;
    logic        flag_z, flag_n, flag_v;

    datapath_seq #(.WIDTH(16), .NREGS(8), .IMM_W(5)) u_dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
        .cmd_shift(cmd_shift), .cmd_aluop(cmd_aluop),
        .cmd_asel(cmd_asel), .cmd_bsel(cmd_bsel), .cmd_imm(cmd_imm), .cmd_data(cmd_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
    );

    logic        sValid, sReady, sResValid, sResReady;
    logic [1:0]  sOp, sRd, sRn, sRm, sShift, sAluop;
    logic        sAsel, sBsel;
    logic [4:0]  sImm;
    logic [7:0]  sData, sResData;
    logic        sZ, sN, sV;

    datapath_seq #(.WIDTH(8), .NREGS(4), .IMM_W(5)) u_small (
        .clk(clk), .reset(reset),
        .cmd_valid(sValid), .cmd_ready(sReady), .cmd_op(sOp),
        .cmd_rd(sRd), .cmd_rn(sRn), .cmd_rm(sRm),
        .cmd_shift(sShift), .cmd_aluop(sAluop),
        .cmd_asel(sAsel), .cmd_bsel(sBsel), .cmd_imm(sImm), .cmd_data(sData),
        .res_valid(sResValid), .res_ready(sResReady), .res_data(sResData),
        .flag_z(sZ), .flag_n(sN), .flag_v(sV)
    );

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  rd, rn, rm;
        logic [1:0]  shift, aluop;
        logic        asel, bsel;
        logic [4:0]  imm;
        logic [15:0] data;
        logic [15:0] expRes;
        logic        expZ, expN, expV;
        int          expLat;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic        z, n, v;
        int          lat;
        string       name;
    } exp_t;

    exp_t expQ[$];
    int compared   = 0;
    int mismatched = 0;

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic reportTimeout(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: timed out, got no response, required one", name);
    endtask

    function automatic vec_t mkVec(input logic [1:0] op, input logic [2:0] rd, rn, rm,
                                   input logic [1:0] shift, aluop, input logic asel, bsel,
                                   input logic [4:0] imm, input logic [15:0] data,
                                   input logic [15:0] res, input logic z, n, v, input int lat);
        vec_t t;
        t.op = op; t.rd = rd; t.rn = rn; t.rm = rm; t.shift = shift; t.aluop = aluop;
        t.asel = asel; t.bsel = bsel; t.imm = imm; t.data = data;
        t.expRes = res; t.expZ = z; t.expN = n; t.expV = v; t.expLat = lat;
        return t;
    endfunction

    // Drive one command, wait for acceptance, then scramble the inputs to prove they were latched.
    task automatic applyStimulus(input vec_t t, input string name, input bit track);
        exp_t e;
        int   waitCnt;
        if (track) begin
            e.res = t.expRes; e.z = t.expZ; e.n = t.expN; e.v = t.expV;
            e.lat = t.expLat; e.name = name;
            expQ.push_back(e);
        end
        @(negedge clk);
        cmd_op = t.op; cmd_rd = t.rd; cmd_rn = t.rn; cmd_rm = t.rm;
        cmd_shift = t.shift; cmd_aluop = t.aluop; cmd_asel = t.asel; cmd_bsel = t.bsel;
        cmd_imm = t.imm; cmd_data = t.data;
        cmd_valid = 1'b1;
        waitCnt = 0;
        while (!cmd_ready && waitCnt < 30) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!cmd_ready) reportTimeout({name, "_accept"});
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_rd = 3'($urandom); cmd_rn = 3'($urandom); cmd_rm = 3'($urandom);
        cmd_shift = 2'($urandom); cmd_aluop = 2'($urandom); cmd_asel = 1'($urandom);
        cmd_bsel = 1'($urandom); cmd_imm = 5'($urandom); cmd_data = 16'($urandom);
    endtask

    // Wait for res_valid counting cycles from acceptance, compare against the scoreboard, then handshake.
    task automatic checkOutput(input bit handshake);
        exp_t e;
        int   lat;
        if (expQ.size() == 0) begin
            reportTimeout("scoreboard_empty");
            return;
        end
        e   = expQ.pop_front();
        lat = 1;
        @(negedge clk);
        while (!res_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        if (!res_valid) begin
            reportTimeout({e.name, "_result"});
            return;
        end
        checkValue({e.name, "_latency"}, 32'(lat), 32'(e.lat));
        checkValue({e.name, "_res_data"}, 32'(res_data), 32'(e.res));
        checkValue({e.name, "_flag_z"}, 32'(flag_z), 32'(e.z));
        checkValue({e.name, "_flag_n"}, 32'(flag_n), 32'(e.n));
        checkValue({e.name, "_flag_v"}, 32'(flag_v), 32'(e.v));
        if (handshake) begin
            res_ready = 1'b1;
            @(posedge clk);
            #1;
            res_ready = 1'b0;
        end
    endtask

    task automatic smallCmd(input logic [1:0] op, rd, rn, input logic bsel, input logic [4:0] imm,
                            input logic [7:0] data, input logic [7:0] expRes,
                            input logic expN, expV, input string name);
        int waitCnt;
        @(negedge clk);
        sOp = op; sRd = rd; sRn = rn; sRm = 2'd0; sShift = 2'd0; sAluop = 2'd0;
        sAsel = 1'b0; sBsel = bsel; sImm = imm; sData = data; sValid = 1'b1;
        waitCnt = 0;
        while (!sReady && waitCnt < 30) begin
            @(negedge clk);
            waitCnt++;
        end
        @(posedge clk);
        #1;
        sValid = 1'b0;
        sData  = 8'($urandom);
        waitCnt = 0;
        @(negedge clk);
        while (!sResValid && waitCnt < 30) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!sResValid) begin
            reportTimeout({name, "_result"});
            return;
        end
        checkValue({name, "_res_data"}, 32'(sResData), 32'(expRes));
        checkValue({name, "_flag_n"}, 32'(sN), 32'(expN));
        checkValue({name, "_flag_v"}, 32'(sV), 32'(expV));
        sResReady = 1'b1;
        @(posedge clk);
        #1;
        sResReady = 1'b0;
    endtask

    localparam logic [1:0] WRI = 2'b00, ALU = 2'b01, CMP = 2'b10, RSV = 2'b11;
    localparam logic [1:0] NS = 2'b00, LSL = 2'b01, LSR = 2'b10, ASR = 2'b11;
    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, AND = 2'b10, MVN = 2'b11;

    initial begin
        vec_t vecs[18];
        vec_t t;
        //                op   rd rn rm shift alu  as bs imm    data      res        z  n  v  lat
        vecs[0]  = mkVec(WRI, 0, 0, 0, NS,  ADD, 0, 0, 5'd0,  16'h0007, 16'h0007, 0, 0, 0, 2);
        vecs[1]  = mkVec(WRI, 1, 0, 0, NS,  ADD, 0, 0, 5'd0,  16'h0002, 16'h0002, 0, 0, 0, 2);
        vecs[2]  = mkVec(ALU, 2, 1, 0, LSL, ADD, 0, 0, 5'd0,  16'h0000, 16'h0010, 0, 0, 0, 4);
        vecs[3]  = mkVec(CMP, 0, 2, 2, NS,  SUB, 0, 0, 5'd0,  16'h0000, 16'h0000, 1, 0, 0, 4);
        vecs[4]  = mkVec(WRI, 3, 0, 0, NS,  ADD, 0, 0, 5'd0,  16'h7FFF, 16'h7FFF, 1, 0, 0, 2);
        vecs[5]  = mkVec(CMP, 0, 2, 0, NS,  ADD, 0, 1, 5'd0,  16'h0000, 16'h0010, 0, 0, 0, 4);
        vecs[6]  = mkVec(ALU, 3, 3, 0, NS,  ADD, 0, 1, 5'd1,  16'h0000, 16'h8000, 0, 1, 1, 4);
        vecs[7]  = mkVec(ALU, 4, 0, 3, ASR, ADD, 1, 0, 5'd0,  16'h0000, 16'hC000, 0, 1, 0, 4);
        vecs[8]  = mkVec(ALU, 5, 0, 0, NS,  MVN, 0, 0, 5'd0,  16'h0000, 16'hFFF8, 0, 1, 0, 4);
        vecs[9]  = mkVec(ALU, 6, 3, 1, NS,  SUB, 0, 0, 5'd0,  16'h0000, 16'h7FFE, 0, 0, 1, 4);
        vecs[10] = mkVec(ALU, 7, 4, 5, NS,  AND, 0, 0, 5'd0,  16'h0000, 16'hC000, 0, 1, 0, 4);
        vecs[11] = mkVec(ALU, 6, 0, 4, LSR, ADD, 1, 0, 5'd0,  16'h0000, 16'h6000, 0, 0, 0, 4);
        vecs[12] = mkVec(RSV, 7, 7, 7, NS,  SUB, 0, 0, 5'd0,  16'h0000, 16'h0000, 1, 0, 0, 4);
        vecs[13] = mkVec(CMP, 0, 7, 0, NS,  ADD, 0, 1, 5'd0,  16'h0000, 16'hC000, 0, 1, 0, 4);
        vecs[14] = mkVec(CMP, 0, 3, 3, NS,  ADD, 0, 0, 5'd0,  16'h0000, 16'h0000, 1, 0, 1, 4);
        vecs[15] = mkVec(ALU, 1, 0, 0, NS,  ADD, 1, 1, 5'h1F, 16'h0000, 16'h001F, 0, 0, 0, 4);
        vecs[16] = mkVec(ALU, 2, 2, 6, NS,  SUB, 0, 0, 5'd0,  16'h0000, 16'hA010, 0, 1, 0, 4);
        vecs[17] = mkVec(CMP, 0, 2, 0, NS,  SUB, 0, 1, 5'd0,  16'h0000, 16'hA010, 0, 1, 0, 4);

        reset = 1'b1;
        cmd_valid = 1'b0; res_ready = 1'b0;
        cmd_op = '0; cmd_rd = '0; cmd_rn = '0; cmd_rm = '0; cmd_shift = '0; cmd_aluop = '0;
        cmd_asel = 1'b0; cmd_bsel = 1'b0; cmd_imm = '0; cmd_data = '0;
        sValid = 1'b0; sResReady = 1'b0; sOp = '0; sRd = '0; sRn = '0; sRm = '0;
        sShift = '0; sAluop = '0; sAsel = 1'b0; sBsel = 1'b0; sImm = '0; sData = '0;

        repeat (3) @(negedge clk);
        checkValue("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        checkValue("reset_res_valid", 32'(res_valid), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkValue("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
        checkValue("post_reset_res_data", 32'(res_data), 32'd0);
        checkValue("post_reset_flags", 32'({flag_z, flag_n, flag_v}), 32'd0);

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i), 1'b1);
            checkOutput(1'b1);
        end

        // Stall in DONE for five cycles while extra commands knock on the door.
        t = mkVec(ALU, 1, 1, 0, NS, ADD, 0, 1, 5'd3, 16'h0000, 16'h0022, 0, 0, 0, 4);
        applyStimulus(t, "stall", 1'b1);
        checkOutput(1'b0);
        for (int c = 0; c < 5; c++) begin
            checkValue($sformatf("stall%0d_res_valid", c), 32'(res_valid), 32'd1);
            checkValue($sformatf("stall%0d_res_data", c), 32'(res_data), 32'h0022);
            checkValue($sformatf("stall%0d_cmd_ready", c), 32'(cmd_ready), 32'd0);
            cmd_op = WRI; cmd_rd = 3'd0; cmd_data = 16'hDEAD;
            cmd_valid = (c % 2 == 0);
            @(negedge clk);
        end
        cmd_valid = 1'b1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        checkValue("stall_release_res_valid", 32'(res_valid), 32'd0);
        checkValue("stall_release_cmd_ready", 32'(cmd_ready), 32'd1);
        t = mkVec(CMP, 0, 0, 0, NS, ADD, 0, 1, 5'd0, 16'h0000, 16'h0007, 0, 0, 0, 4);
        applyStimulus(t, "stall_r0_intact", 1'b1);
        checkOutput(1'b1);
        t = mkVec(CMP, 0, 3, 0, NS, ADD, 0, 1, 5'd0, 16'h0000, 16'h8000, 0, 1, 0, 4);
        applyStimulus(t, "pre_abort_r3", 1'b1);
        checkOutput(1'b1);

        // Reset arrives while the command sits in RDB.
        t = mkVec(ALU, 5, 0, 0, NS, ADD, 1, 1, 5'd9, 16'h0000, 16'h0009, 0, 0, 0, 4);
        applyStimulus(t, "aborted", 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checkValue("abort_reset_cmd_ready", 32'(cmd_ready), 32'd0);
        checkValue("abort_reset_res_valid", 32'(res_valid), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkValue("abort_idle_cmd_ready", 32'(cmd_ready), 32'd1);
        checkValue("abort_res_valid", 32'(res_valid), 32'd0);
        checkValue("abort_res_data", 32'(res_data), 32'd0);
        checkValue("abort_flags", 32'({flag_z, flag_n, flag_v}), 32'd0);
        t = mkVec(CMP, 0, 5, 0, NS, ADD, 0, 1, 5'd0, 16'h0000, 16'h0000, 1, 0, 0, 4);
        applyStimulus(t, "abort_r5_cleared", 1'b1);
        checkOutput(1'b1);
        t = mkVec(CMP, 0, 0, 0, NS, ADD, 0, 1, 5'd0, 16'h0000, 16'h0000, 1, 0, 0, 4);
        applyStimulus(t, "abort_r0_cleared", 1'b1);
        checkOutput(1'b1);

        smallCmd(WRI, 2'd1, 2'd0, 1'b0, 5'd0, 8'h7F, 8'h7F, 1'b0, 1'b0, "small_wri_r1");
        smallCmd(ALU, 2'd2, 2'd1, 1'b1, 5'd1, 8'h00, 8'h80, 1'b1, 1'b1, "small_add_ovf");
        smallCmd(WRI, 2'd3, 2'd0, 1'b0, 5'd0, 8'h55, 8'h55, 1'b1, 1'b1, "small_wri_r3");
        smallCmd(CMP, 2'd0, 2'd3, 1'b1, 5'd0, 8'h00, 8'h55, 1'b0, 1'b0, "small_read_r3");
        smallCmd(CMP, 2'd0, 2'd2, 1'b1, 5'd0, 8'h00, 8'h80, 1'b1, 1'b0, "small_read_r2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/datapath_seq.md
Name: datapath_seq

Overview:
- Parametrised successor of the lab datapath: register file, A/B/C pipeline registers, shifter, operand muxes, ALU and status flags.
- Adds an internal sequencer, so one command runs a complete multi-cycle operation without external per-cycle control.
- Commands are accepted on a valid/ready channel; results leave on a valid/ready channel. Sits between the controller FSM and the register/ALU resources of the RISC machine.

Parameters:
WIDTH, 16, data/register width in bits (>=4)
NREGS, 8, number of registers (power of 2, >=2); RW = $clog2(NREGS) is a local parameter
IMM_W, 5, immediate width; zero-extended to WIDTH when used as B operand

Ports:
clk  in  1  single clock, all state updates on rising edge
reset  in  1  synchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_op  in  2  00 WRI (write cmd_data to rd), 01 ALU (execute and write back), 10 CMP (flags and C only), 11 reserved (treated as CMP)
cmd_rd  in  RW  destination register
cmd_rn  in  RW  A-source register
cmd_rm  in  RW  B-source register
cmd_shift  in  2  00 none, 01 LSL1, 10 LSR1 (MSB<=0), 11 ASR1 (MSB kept)
cmd_aluop  in  2  00 ADD, 01 SUB (A-B), 10 AND, 11 MVN (~B)
cmd_asel  in  1  1: A operand forced to 0
cmd_bsel  in  1  1: B operand is zero-extended cmd_imm, not the shifter output
cmd_imm  in  IMM_W  immediate
cmd_data  in  WIDTH  write data for WRI
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  WIDTH  C register
flag_z  out  1  result == 0
flag_n  out  1  result MSB
flag_v  out  1  signed overflow

Behaviour:
- Reset applies in any state, including mid-operation:
  - state<=IDLE; all registers, A, B and C cleared to 0; flags cleared.
  - cmd_ready=0 during the reset cycle; res_valid=0.
  - No register write occurs for an aborted command.
- All cmd_* fields are latched on acceptance (cmd_valid & cmd_ready); later input changes have no effect.
- States: IDLE, RDA, RDB, EXEC, DONE.
  - IDLE: cmd_ready=1. On acceptance, ALU/CMP go to RDA and WRI goes to EXEC.
  - RDA: A<=R[rn]. Next state RDB.
  - RDB: B<=R[rm]. Next state EXEC.
  - EXEC: C<=result.
    - ALU: R[rd]<=result.
    - WRI: R[rd]<=cmd_data and C<=cmd_data.
    - CMP: no register write.
    - Next state DONE.
  - DONE: res_valid=1 and res_data=C, both held stable until res_ready=1; the handshake cycle returns to IDLE.
- cmd_ready is asserted only in IDLE. cmd_valid in any other state is ignored (no queueing).
- Latency, counting the accept cycle as 0: ALU/CMP res_valid in cycle 4; WRI res_valid in cycle 2.
- Back-to-back throughput: the next command is accepted no earlier than the cycle after the DONE handshake.
- Datapath:
  - Ain = asel ? 0 : A.
  - Bin = bsel ? zext(imm) : shift(B).
  - result = aluop(Ain, Bin), computed modulo 2^WIDTH.
- Flags are updated in EXEC for ALU/CMP only; WRI leaves them unchanged.
  - Z = (result==0).
  - N = result[WIDTH-1].
  - V, ADD: operands have the same sign and the result sign differs.
  - V, SUB: operand signs differ and the result sign differs from A.
  - V = 0 for AND and MVN.
- Register read/write hazards: a command reads register values written by any earlier completed command (the write lands in EXEC, before DONE).
- Register file has exactly one write port. Reads happen only in RDA and RDB.

Test Plan:
- Reset; WRI rd=0 data=0x0007 accepted cycle 0 -> res_valid cycle 2, res_data=0x0007, flags 000, R0=0x0007.
- WRI R1=0x0002; ALU rd=2 rn=1 rm=0 shift=LSL1 ADD -> res_data=0x0010 in cycle 4, Z=N=V=0; CMP rn=2 rm=2 SUB -> res_data=0x0000, Z=1, R2 still 0x0010.
- WRI R3=0x7FFF; ALU rd=3 rn=3 bsel=1 imm=1 ADD -> 0x8000, N=1 V=1; then ALU rd=4 asel=1 rm=3 shift=ASR1 ADD -> 0xC000; MVN of R0 -> 0xFFF8, N=1, V=0.
- Hold res_ready=0 for 5 cycles in DONE while pulsing cmd_valid -> res_valid/res_data stable, cmd_ready=0, extra commands not executed; res_ready=1 -> IDLE next cycle.
- Assert reset during RDB of ALU rd=5 -> next cycle IDLE, R5=0, flags 000, res_valid=0, cmd_ready=1 after reset deasserts.
- WIDTH=8, NREGS=4 build: ADD 0x7F+0x01 -> 0x80, V=1; rd index wraps within 2 bits.
